// File: rtl/bus_arbiter.sv
// Two-requester round-robin bus arbiter with memory/peripheral address decode
// and a per-transaction timeout that turns a silent target into a bus error.
module bus_arbiter #(
  parameter int PER_BIT = 31,
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  output logic        m0_error,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic        m1_error,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        per_valid,
  output logic [31:0] per_addr,
  output logic [31:0] per_wdata,
  output logic [3:0]  per_wstrb,
  input  logic [31:0] per_rdata,
  input  logic        per_ready,
  output logic        grant
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic        sel_per_q, sel_per_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        mem_valid_q, mem_valid_d, per_valid_q, per_valid_d;
  logic        m0_ready_q, m0_ready_d, m1_ready_q, m1_ready_d;
  logic        m0_error_q, m0_error_d, m1_error_q, m1_error_d;
  logic [31:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic        tgt_ready_s;
  logic [31:0] tgt_rdata_s;

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= 1'b1;
      sel_per_q   <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      wstrb_q     <= 4'h0;
      count_q     <= '0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
      mem_valid_q <= 1'b0;
      per_valid_q <= 1'b0;
      m0_ready_q  <= 1'b0;
      m1_ready_q  <= 1'b0;
      m0_error_q  <= 1'b0;
      m1_error_q  <= 1'b0;
      m0_rdata_q  <= 32'h0;
      m1_rdata_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      sel_per_q   <= sel_per_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      count_q     <= count_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      mem_valid_q <= mem_valid_d;
      per_valid_q <= per_valid_d;
      m0_ready_q  <= m0_ready_d;
      m1_ready_q  <= m1_ready_d;
      m0_error_q  <= m0_error_d;
      m1_error_q  <= m1_error_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  // Next state: arbitration, field latching, completion and timeout
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    sel_per_d   = sel_per_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    count_d     = count_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    // Only the selected target's ready counts, and only while in BUSY
    tgt_ready_s = sel_per_q ? per_ready : mem_ready;
    tgt_rdata_s = sel_per_q ? per_rdata : mem_rdata;
    case (state_q)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          if (m0_valid && m1_valid) begin
            grant_d = ~grant_q;
          end else if (m0_valid) begin
            grant_d = 1'b0;
          end else begin
            grant_d = 1'b1;
          end
          addr_d    = grant_d ? m1_addr  : m0_addr;
          wdata_d   = grant_d ? m1_wdata : m0_wdata;
          wstrb_d   = grant_d ? m1_wstrb : m0_wstrb;
          sel_per_d = addr_d[PER_BIT];
          count_d   = '0;
          state_d   = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        count_d = count_q + 1'b1;
        if (tgt_ready_s) begin
          rdata_d = tgt_rdata_s;
          err_d   = 1'b0;
          state_d = DONE;
        end else if (count_q == CW'(TIMEOUT - 1)) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output next values, derived from the next state so outputs stay registered
  always_comb begin
    mem_valid_d = (state_d == BUSY) && !sel_per_d;
    per_valid_d = (state_d == BUSY) &&  sel_per_d;
    m0_ready_d  = (state_d == DONE) && !grant_d;
    m1_ready_d  = (state_d == DONE) &&  grant_d;
    m0_error_d  = m0_ready_d && err_d;
    m1_error_d  = m1_ready_d && err_d;
    m0_rdata_d  = m0_ready_d ? rdata_d : 32'h0;
    m1_rdata_d  = m1_ready_d ? rdata_d : 32'h0;
  end

  assign mem_valid = mem_valid_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign per_valid = per_valid_q;
  assign per_addr  = addr_q;
  assign per_wdata = wdata_q;
  assign per_wstrb = wstrb_q;
  assign m0_ready  = m0_ready_q;
  assign m1_ready  = m1_ready_q;
  assign m0_error  = m0_error_q;
  assign m1_error  = m1_error_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign grant     = grant_q;

endmodule
